// File: rtl/mem_access_unit_if.sv
// Request/response and RAM-port bundle for mem_access_unit.
// The unit uses the slave modport; the execute stage plus RAM use master.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [29:0] mem_address;
  logic        mem_wren;
  logic [31:0] mem_data;
  logic [31:0] mem_q;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_q,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_wren, mem_data
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_q,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_wren, mem_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front end for a word-addressed synchronous RAM.
// Big-endian lanes; sub-word stores use read-modify-write.
module mem_access_unit #(
  parameter int unsigned MEM_WORDS = 256
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_ERR,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_we;
  logic        r_signed;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;

  logic [29:0] r_mem_address;
  logic        r_mem_wren;
  logic [31:0] r_mem_data;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic        w_accept;
  logic        w_req_err;
  logic        w_req_word_store;
  logic        w_word_store;
  logic [7:0]  w_lane_byte;
  logic [15:0] w_lane_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  assign w_accept         = bus.req_valid && (r_state == S_IDLE);
  assign w_req_word_store = bus.req_we && (bus.req_size == 2'b10);
  assign w_word_store     = r_we && (r_size == 2'b10);

  always_comb begin
    w_req_err = 1'b0;
    case (bus.req_size)
      2'b00:   w_req_err = 1'b0;
      2'b01:   w_req_err = bus.req_addr[0];
      2'b10:   w_req_err = |bus.req_addr[1:0];
      default: w_req_err = 1'b1;
    endcase
    if ({2'b00, bus.req_addr[31:2]} >= MEM_WORDS) begin
      w_req_err = 1'b1;
    end
  end

  // Offset 0 is the most significant lane.
  always_comb begin
    w_lane_byte = bus.mem_q[31:24];
    case (r_off)
      2'd0: w_lane_byte = bus.mem_q[31:24];
      2'd1: w_lane_byte = bus.mem_q[23:16];
      2'd2: w_lane_byte = bus.mem_q[15:8];
      2'd3: w_lane_byte = bus.mem_q[7:0];
      default: w_lane_byte = bus.mem_q[31:24];
    endcase
    w_lane_half = r_off[1] ? bus.mem_q[15:0] : bus.mem_q[31:16];

    w_load_data = bus.mem_q;
    case (r_size)
      2'b00:   w_load_data = {{24{r_signed & w_lane_byte[7]}}, w_lane_byte};
      2'b01:   w_load_data = {{16{r_signed & w_lane_half[15]}}, w_lane_half};
      default: w_load_data = bus.mem_q;
    endcase
  end

  always_comb begin
    w_merged = bus.mem_q;
    if (r_size == 2'b00) begin
      case (r_off)
        2'd0: w_merged[31:24] = r_wdata[7:0];
        2'd1: w_merged[23:16] = r_wdata[7:0];
        2'd2: w_merged[15:8]  = r_wdata[7:0];
        2'd3: w_merged[7:0]   = r_wdata[7:0];
        default: w_merged = bus.mem_q;
      endcase
    end else if (r_size == 2'b01) begin
      if (r_off[1]) begin
        w_merged[15:0] = r_wdata[15:0];
      end else begin
        w_merged[31:16] = r_wdata[15:0];
      end
    end else begin
      w_merged = r_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = w_req_err ? S_ERR : S_ISSUE;
        end
      end
      S_ISSUE: w_next_state = w_word_store ? S_RESP : S_WAIT;
      S_WAIT:  w_next_state = r_we ? S_WRITE : S_RESP;
      S_WRITE: w_next_state = S_RESP;
      S_ERR:   w_next_state = S_RESP;
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // RAM port registers are loaded one state ahead so they are stable for the
  // whole ISSUE/WRITE cycle in which the RAM samples them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we          <= 1'b0;
      r_signed      <= 1'b0;
      r_size        <= '0;
      r_off         <= '0;
      r_wdata       <= '0;
      r_mem_address <= '0;
      r_mem_wren    <= 1'b0;
      r_mem_data    <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we     <= bus.req_we;
            r_signed <= bus.req_signed;
            r_size   <= bus.req_size;
            r_off    <= bus.req_addr[1:0];
            r_wdata  <= bus.req_wdata;
            if (!w_req_err) begin
              r_mem_address <= bus.req_addr[31:2];
              r_mem_wren    <= w_req_word_store;
              if (w_req_word_store) begin
                r_mem_data <= bus.req_wdata;
              end
            end
          end
        end
        S_ISSUE: begin
          r_mem_wren <= 1'b0;
          if (w_word_store) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (r_we) begin
            r_mem_data <= w_merged;
            r_mem_wren <= 1'b1;
          end else begin
            r_rsp_rdata <= w_load_data;
            r_rsp_err   <= 1'b0;
          end
        end
        S_WRITE: begin
          r_mem_wren  <= 1'b0;
          r_rsp_rdata <= '0;
          r_rsp_err   <= 1'b0;
        end
        S_ERR: begin
          r_rsp_rdata <= '0;
          r_rsp_err   <= 1'b1;
        end
        default: begin
          r_mem_wren <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready   = (r_state == S_IDLE);
  assign bus.rsp_valid   = (r_state == S_RESP);
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_wren    = r_mem_wren;
  assign bus.mem_data    = r_mem_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit with a synchronous RAM
// model and a byte-arithmetic reference of the load/store rules.
module tb_mem_access_unit;
  localparam int unsigned MEM_WORDS = 256;
  localparam int NRAND = 24;
  localparam int NB2B  = 24;

  typedef struct {
    logic        err;
    logic [31:0] rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] init_mem [MEM_WORDS];
  logic [31:0] ram      [MEM_WORDS];
  logic [31:0] ref_mem  [MEM_WORDS];
  logic        ram_load = 1'b1;
  int          wr_cnt = 0;
  logic [29:0] last_wa = '0;
  logic [31:0] last_wd = '0;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) ram[i] <= init_mem[i];
    end else if (bus.mem_wren) begin
      ram[bus.mem_address[7:0]] <= bus.mem_data;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= bus.mem_address;
      last_wd <= bus.mem_data;
    end
    bus.mem_q <= ram[bus.mem_address[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: bytes numbered from the MSB, sizes as byte counts.
  function automatic void model(input logic we, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic err, output logic [31:0] rd,
                                output int lat, output int pc, output logic [31:0] nw);
    int unsigned ai, w, off, nb, sh, mask, v;
    ai   = a;
    w    = ai >> 2;
    off  = ai & 3;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err  = (sz == 2'd3) || (off % nb != 0) || (w >= MEM_WORDS);
    rd   = '0;
    nw   = '0;
    pc   = 0;
    lat  = 2;
    if (err) return;
    sh   = (4 - off - nb) * 8;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 1);
    if (!we) begin
      v = (ref_mem[w] >> sh) & mask;
      if (sg && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
      rd  = v;
      lat = 3;
    end else begin
      ref_mem[w] = (ref_mem[w] & ~(mask << sh)) | ((wd & mask) << sh);
      nw  = ref_mem[w];
      lat = (nb == 4) ? 2 : 4;
      pc  = (nb == 4) ? 1 : 3;
    end
  endfunction

  task automatic drive(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
  endtask

  task automatic gen(output logic we, output logic [1:0] sz, output logic sg,
                     output logic [31:0] a, output logic [31:0] wd);
    we = 1'($urandom_range(0, 1));
    sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    sg = 1'($urandom_range(0, 1));
    a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63));
    wd = $urandom;
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd_obs);
    logic        e_err, o_err, got;
    logic [31:0] e_rd, e_word, o_rd;
    logic [15:0] obs_mask, exp_mask;
    int          e_lat, e_pc, lat, cnt0;
    string       tg;
    model(we, sz, sg, a, wd, e_err, e_rd, e_lat, e_pc, e_word);
    tg = $sformatf("%s sz%0d a=%h", we ? "st" : "ld", sz, a);
    rd_obs = '0;
    @(negedge clk);
    drive(we, sz, sg, a, wd);
    bus.req_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (bus.req_ready) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      check({tg, " accept_timeout"}, 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    cnt0 = wr_cnt;
    @(posedge clk);
    obs_mask = '0;
    got  = 1'b0;
    lat  = 0;
    o_rd = '0;
    o_err = 1'b0;
    for (int n = 1; n <= 12 && !got; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus.req_valid = 1'b0;
        check({tg, " busy_ready"}, 32'(bus.req_ready), 32'd0);
      end
      obs_mask[n] = bus.mem_wren;
      if (bus.rsp_valid) begin
        got   = 1'b1;
        lat   = n;
        o_rd  = bus.rsp_rdata;
        o_err = bus.rsp_err;
      end
    end
    exp_mask = (e_pc != 0) ? (16'd1 << e_pc) : 16'd0;
    check({tg, " latency"}, 32'(lat), 32'(e_lat));
    check({tg, " rdata"}, o_rd, e_rd);
    check({tg, " err"}, 32'(o_err), 32'(e_err));
    check({tg, " wren_cycles"}, 32'(obs_mask), 32'(exp_mask));
    check({tg, " wren_count"}, 32'(wr_cnt - cnt0), (e_pc != 0) ? 32'd1 : 32'd0);
    if (e_pc != 0) begin
      check({tg, " waddr"}, 32'(last_wa), a >> 2);
      check({tg, " wdata"}, last_wd, e_word);
    end
    @(negedge clk);
    check({tg, " rsp_pulse"}, 32'(bus.rsp_valid), 32'd0);
    check({tg, " rdata_hold"}, bus.rsp_rdata, o_rd);
    rd_obs = o_rd;
  endtask

  initial begin
    logic [31:0] obs;
    logic        cw, cg, acc;
    logic [1:0]  cs;
    logic [31:0] ca, cd, d_rd, d_w;
    logic        d_err;
    int          d_lat, d_pc, c0, n_acc, n_rsp;
    exp_t        q[$];
    exp_t        ex;

    bus.req_valid = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < int'(MEM_WORDS); i++) init_mem[i] = $urandom;
    init_mem[2] = 32'h80FF7F01;
    for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = init_mem[i];

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_mem_wren", 32'(bus.mem_wren), 32'd0);
    check("rst_mem_address", 32'(bus.mem_address), 32'd0);
    check("rst_mem_data", bus.mem_data, 32'd0);
    ram_load = 1'b0;
    rst_n = 1'b1;

    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'd0, obs);  check("tp_lw8", obs, 32'h80FF7F01);
    do_req(1'b0, 2'd0, 1'b1, 32'h8, 32'd0, obs);  check("tp_lb8", obs, 32'hFFFFFF80);
    do_req(1'b0, 2'd0, 1'b0, 32'h9, 32'd0, obs);  check("tp_lbu9", obs, 32'h000000FF);
    do_req(1'b0, 2'd1, 1'b1, 32'h8, 32'd0, obs);  check("tp_lh8", obs, 32'hFFFF80FF);
    do_req(1'b0, 2'd1, 1'b0, 32'hA, 32'd0, obs);  check("tp_lhuA", obs, 32'h00007F01);
    do_req(1'b1, 2'd0, 1'b0, 32'hA, 32'h123456AB, obs);
    check("tp_sbA_rdata", obs, 32'd0);
    check("tp_sbA_merged", last_wd, 32'h80FFAB01);
    do_req(1'b1, 2'd2, 1'b0, 32'h4, 32'hDEADBEEF, obs);
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'd0, obs);  check("tp_lw4", obs, 32'hDEADBEEF);

    do_req(1'b0, 2'd1, 1'b0, 32'h9, 32'd0, obs);
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'd0, obs);  check("after_lh9", obs, 32'h80FFAB01);
    do_req(1'b0, 2'd2, 1'b0, 32'h6, 32'd0, obs);
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'd0, obs);  check("after_lw6", obs, 32'h80FFAB01);
    do_req(1'b1, 2'd3, 1'b0, 32'h0, 32'h5A5A5A5A, obs);
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'd0, obs);  check("after_sz3", obs, 32'h80FFAB01);
    do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'd0, obs);
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'd0, obs);  check("after_lw400", obs, 32'h80FFAB01);

    // Reset asserted while an sh is waiting on its read data.
    @(negedge clk);
    drive(1'b1, 2'd1, 1'b0, 32'h8, 32'h0000C0DE);
    bus.req_valid = 1'b1;
    c0 = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(bus.req_ready), 32'd1);
    check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("arst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("arst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("arst_mem_wren", 32'(bus.mem_wren), 32'd0);
    check("arst_mem_address", 32'(bus.mem_address), 32'd0);
    check("arst_mem_data", bus.mem_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_no_write", 32'(wr_cnt - c0), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'd0, obs);  check("arst_lw8", obs, 32'h80FFAB01);

    for (int i = 0; i < NRAND; i++) begin
      gen(cw, cs, cg, ca, cd);
      do_req(cw, cs, cg, ca, cd, obs);
    end

    // Back-to-back with req_valid held high throughout.
    n_acc = 0;
    n_rsp = 0;
    @(negedge clk);
    gen(cw, cs, cg, ca, cd);
    drive(cw, cs, cg, ca, cd);
    bus.req_valid = 1'b1;
    for (int cyc = 0; cyc < 400 && n_rsp < NB2B; cyc++) begin
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          check("b2b_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          ex = q.pop_front();
          check("b2b_rdata", bus.rsp_rdata, ex.rd);
          check("b2b_err", 32'(bus.rsp_err), 32'(ex.err));
        end
        n_rsp++;
      end
      acc = bus.req_ready && bus.req_valid;
      @(negedge clk);
      if (acc) begin
        model(cw, cs, cg, ca, cd, d_err, d_rd, d_lat, d_pc, d_w);
        ex.err = d_err;
        ex.rd  = d_rd;
        q.push_back(ex);
        n_acc++;
        if (n_acc < NB2B) begin
          gen(cw, cs, cg, ca, cd);
          drive(cw, cs, cg, ca, cd);
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
    check("b2b_accepts", 32'(n_acc), 32'(NB2B));
    check("b2b_responses", 32'(n_rsp), 32'(NB2B));
    bus.req_valid = 1'b0;
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'd0, obs);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
